arm_multicycle_ctrl_fsm: RTL and testbench

Main control FSM plus ALU-control decode for the multicycle ARM core. It sits directly upstream of the condition-check/flag-update stage. It produces the raw PCS, RegW, MemW and FlagW requests, which that stage gates with the instruction condition. It also drives the datapath mux selects, IRWrite and NextPC directly; these are not condition-gated.

---
 rtl/arm_multicycle_ctrl_fsm.sv | 186 ++++++++++++++++++
 tb/tb_arm_multicycle_ctrl_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_ctrl_fsm.sv
// arm_multicycle_ctrl_fsm
// Main control FSM and ALU-control decode for the multicycle ARM core.
// PCS, RegW, MemW and FlagW are raw requests. The downstream condition
// stage gates them with the instruction condition. All other outputs
// drive the datapath directly.
// State-only controls are registered together with the state register,
// so each one is a pure function of the current state. ALUControl, FlagW
// and PCS also depend on the live Funct and Rd inputs, so they are decoded
// combinationally from those registered controls.
// Optional feature macro: ARM_FSM_PERF_CNT_EN (InstrCnt / CycleCnt counters).
module arm_multicycle_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUControl,
  output logic [1:0]       FlagW,
  output logic             PCS,
  output logic             RegW,
  output logic             MemW,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCnt,
  output logic [CNT_W-1:0] CycleCnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       aluop;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic [1:0] alu_ctrl_s;
  logic [1:0] flagw_s;

  // Moore output table. Any code that is not a named state decodes as UNKNOWN.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1; c.nextpc = 1'b1;
        c.alusrca = 2'b01; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
      end
      S_DECODE: begin
        c.alusrca = 2'b01; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
      end
      S_MEMADR:   begin c.alusrca = 2'b00; c.alusrcb = 2'b01; end
      S_MEMRD:    begin c.adrsrc = 1'b1; c.resultsrc = 2'b00; end
      S_MEMWB:    begin c.resultsrc = 2'b01; c.regw = 1'b1; end
      S_MEMWR:    begin c.adrsrc = 1'b1; c.resultsrc = 2'b00; c.memw = 1'b1; end
      S_EXECUTER: begin c.alusrca = 2'b00; c.alusrcb = 2'b00; c.aluop = 1'b1; end
      S_EXECUTEI: begin c.alusrca = 2'b00; c.alusrcb = 2'b01; c.aluop = 1'b1; end
      S_ALUWB:    begin c.resultsrc = 2'b00; c.regw = 1'b1; end
      S_BRANCH: begin
        c.alusrca = 2'b10; c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.branch = 1'b1;
      end
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Next-state selection. UNKNOWN and unused codes return to FETCH so the core never hangs.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register and registered Moore controls. Reset forces FETCH and drops RegW/MemW at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_of(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
    end
  end

  // ALU decode from Funct. It is active only in the execute states.
  always_comb begin
    alu_ctrl_s = 2'b00;
    flagw_s    = 2'b00;
    if (ctrl_q.aluop) begin
      case (Funct[4:1])
        4'b0100: alu_ctrl_s = 2'b00;
        4'b0010: alu_ctrl_s = 2'b01;
        4'b0000: alu_ctrl_s = 2'b10;
        4'b1100: alu_ctrl_s = 2'b11;
        default: alu_ctrl_s = 2'b00;
      endcase
      flagw_s[1] = Funct[0];
      flagw_s[0] = Funct[0] & ((alu_ctrl_s == 2'b00) | (alu_ctrl_s == 2'b01));
    end else begin
      alu_ctrl_s = 2'b00;
      flagw_s    = 2'b00;
    end
  end

  assign IRWrite    = ctrl_q.irwrite;
  assign NextPC     = ctrl_q.nextpc;
  assign AdrSrc     = ctrl_q.adrsrc;
  assign ALUSrcA    = ctrl_q.alusrca;
  assign ALUSrcB    = ctrl_q.alusrcb;
  assign ResultSrc  = ctrl_q.resultsrc;
  assign RegW       = ctrl_q.regw;
  assign MemW       = ctrl_q.memw;
  assign Illegal    = ctrl_q.illegal;
  assign ALUControl = alu_ctrl_s;
  assign FlagW      = flagw_s;
  assign PCS        = (ctrl_q.regw & (Rd == 4'hF)) | ctrl_q.branch;

`ifdef ARM_FSM_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, cycle_cnt_q;

  // Cycle counter and retired-instruction counter. Returns from UNKNOWN are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if ((state_q == S_MEMWB) || (state_q == S_MEMWR) ||
          (state_q == S_ALUWB) || (state_q == S_BRANCH)) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end else begin
        instr_cnt_q <= instr_cnt_q;
      end
    end
  end

  assign InstrCnt = instr_cnt_q;
  assign CycleCnt = cycle_cnt_q;
`else
  assign InstrCnt = {CNT_W{1'b0}};
  assign CycleCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_arm_multicycle_ctrl_fsm.sv
// Testbench for arm_multicycle_ctrl_fsm.
// The reference model describes each instruction class as a per-cycle
// output table. Counter checks are active when ARM_FSM_PERF_CNT_EN is defined.
module tb_arm_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic        IRWrite, NextPC, AdrSrc, PCS, RegW, MemW, Illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic [31:0] InstrCnt, CycleCnt;

  int n_vec = 0;
  int n_bad = 0;
  longint exp_cycle;
  longint exp_instr;

  always #5 clk = ~clk;

  arm_multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .Illegal(Illegal), .InstrCnt(InstrCnt), .CycleCnt(CycleCnt)
  );

`ifdef ARM_FSM_PERF_CNT_EN
  logic       w_irw, w_npc, w_adr, w_pcs, w_regw, w_memw, w_ill;
  logic [1:0] w_sa, w_sb, w_rs, w_alu, w_fw;
  logic [3:0] ic4, cc4;

  arm_multicycle_ctrl_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(w_irw), .NextPC(w_npc), .AdrSrc(w_adr),
    .ALUSrcA(w_sa), .ALUSrcB(w_sb), .ResultSrc(w_rs),
    .ALUControl(w_alu), .FlagW(w_fw), .PCS(w_pcs), .RegW(w_regw),
    .MemW(w_memw), .Illegal(w_ill), .InstrCnt(ic4), .CycleCnt(cc4)
  );
`endif

  wire [16:0] obs_vec = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                         ALUControl, FlagW, PCS, RegW, MemW, Illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Number of cycles an instruction occupies, from its opcode class.
  function automatic int instr_len(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b11 || op == 2'b10) return 3;
    if (op == 2'b01) return f[0] ? 5 : 4;
    return 4;
  endfunction

  // Expected output vector on cycle k of an instruction.
  function automatic logic [16:0] expect_vec(input logic [1:0] op, input logic [5:0] f,
                                             input logic [3:0] rd, input int k);
    logic irw, npc, adr, pcs, regw, memw, ill;
    logic [1:0] sa, sb, rs, alu, fw;
    int cmd;
    {irw, npc, adr, pcs, regw, memw, ill} = 7'b0;
    {sa, sb, rs, alu, fw} = 10'b0;
    if (k == 0) begin
      irw = 1'b1; npc = 1'b1; sa = 2'b01; sb = 2'b10; rs = 2'b10;
    end else if (k == 1) begin
      sa = 2'b01; sb = 2'b10; rs = 2'b10;
    end else if (op == 2'b11) begin
      ill = 1'b1;
    end else if (op == 2'b10) begin
      sa = 2'b10; sb = 2'b01; rs = 2'b10; pcs = 1'b1;
    end else if (op == 2'b01) begin
      if (k == 2) sb = 2'b01;
      else if (k == 3) begin adr = 1'b1; memw = ~f[0]; end
      else begin rs = 2'b01; regw = 1'b1; pcs = (rd == 4'd15); end
    end else begin
      if (k == 2) begin
        sb = f[5] ? 2'b01 : 2'b00;
        cmd = int'(f[4:1]);
        alu = (cmd == 4) ? 2'd0 : (cmd == 2) ? 2'd1 : (cmd == 0) ? 2'd2 : (cmd == 12) ? 2'd3 : 2'd0;
        fw[1] = f[0];
        fw[0] = f[0] && (alu < 2'd2);
      end else begin
        regw = 1'b1; pcs = (rd == 4'd15);
      end
    end
    return {irw, npc, adr, sa, sb, rs, alu, fw, pcs, regw, memw, ill};
  endfunction

  task automatic check_counters(input string tag);
`ifdef ARM_FSM_PERF_CNT_EN
    check({tag, "_cyc"}, CycleCnt, 32'(exp_cycle));
    check({tag, "_ins"}, InstrCnt, 32'(exp_instr));
    check({tag, "_cyc4"}, {28'd0, cc4}, 32'(exp_cycle % 16));
    check({tag, "_ins4"}, {28'd0, ic4}, 32'(exp_instr % 16));
`else
    check({tag, "_cyc0"}, CycleCnt, 32'd0);
    check({tag, "_ins0"}, InstrCnt, 32'd0);
`endif
  endtask

  // Must be called at a negedge with the FSM in FETCH. It returns at the negedge
  // where the next instruction starts, or stays on cycle abort_k when abort_k >= 0.
  task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input int abort_k);
    int len;
    len = instr_len(op, f);
    Op = op; Funct = f; Rd = rd;
    #1;
    check_counters(tag);
    for (int k = 0; k < len; k++) begin
      if (k > 0) #1;
      check($sformatf("%s_c%0d", tag, k), {15'd0, obs_vec}, {15'd0, expect_vec(op, f, rd, k)});
      if (k == abort_k) return;
      @(negedge clk);
      exp_cycle++;
    end
    if (op != 2'b11) exp_instr++;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_memw"}, {31'd0, MemW}, 32'd0);
    check({tag, "_regw"}, {31'd0, RegW}, 32'd0);
    check({tag, "_irw"}, {31'd0, IRWrite}, 32'd1);
    check({tag, "_srcb"}, {30'd0, ALUSrcB}, 32'd2);
    check({tag, "_vec"}, {15'd0, obs_vec}, {15'd0, expect_vec(2'b00, 6'd0, 4'd0, 0)});
    @(negedge clk);
    reset = 1'b0;
    exp_cycle = 0;
    exp_instr = 0;
  endtask

  logic [3:0] cmds [4];

  initial begin
    logic [1:0] op;
    logic [5:0] f;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    @(negedge clk);
    do_reset("rst0");

    // Counter scenario: ADD, LDR, B, illegal takes 15 cycles with 3 retired.
    run_instr("add_r1", 2'b00, 6'b001000, 4'd1, -1);
    run_instr("ldr", 2'b01, 6'b011001, 4'd2, -1);
    run_instr("b", 2'b10, 6'b000000, 4'd0, -1);
    run_instr("ill", 2'b11, 6'b000000, 4'd0, -1);
`ifdef ARM_FSM_PERF_CNT_EN
    #1;
    check("perf_ins3", InstrCnt, 32'd3);
    check("perf_cyc15", CycleCnt, 32'd15);
`endif
    run_instr("subs_pc", 2'b00, 6'b000101, 4'd15, -1);
    run_instr("str", 2'b01, 6'b011000, 4'd3, -1);
    run_instr("ldr_pc", 2'b01, 6'b011001, 4'd15, -1);
    run_instr("orrs", 2'b00, 6'b111001, 4'd4, -1);
    run_instr("ands", 2'b00, 6'b000001, 4'd5, -1);

    // Reset on the MemW cycle of a store.
    run_instr("str_abort", 2'b01, 6'b000000, 4'd6, 3);
    do_reset("rst_memwr");

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      if ($urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 3)];
      run_instr($sformatf("rnd%0d", i), op, f, 4'($urandom), -1);
    end
    #1;
    check_counters("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
